// File: rtl/axil_pattern_pkg.sv
// axil_pattern_pkg: shared FSM states, run modes and AXI response codes
package axil_pattern_pkg;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, FINISH} state_e;
    typedef enum logic [1:0] {
        MODE_WRITE     = 2'b00,
        MODE_READ      = 2'b01,
        MODE_WR_VERIFY = 2'b10,
        MODE_RSVD      = 2'b11
    } mode_e;
    localparam logic [1:0] OKAY = 2'b00;
endpackage

// File: rtl/axil_pattern_if.sv
// axil_pattern_if: AXI-Lite bus (32-bit data) with master and slave views
interface axil_pattern_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid, awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid, wready;
    logic [1:0]        bresp;
    logic              bvalid, bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid, arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid, rready;
    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );
    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_pattern_timeout.sv
// axil_pattern_timeout: counts cycles since clr, flags when the limit is reached
module axil_pattern_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    // cycles spent in the current state, parked at the limit
    always_ff @(posedge clk) begin
        cnt <= (rst || clr) ? '0 : expired ? cnt : cnt + CW'(1);
    end
    assign expired = cnt == CW'(TIMEOUT_CYC);
endmodule

// File: rtl/axil_pattern_master.sv
// axil_pattern_master: writes and/or read-verifies an incrementing pattern over AXI-Lite
module axil_pattern_master
    import axil_pattern_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                SECTOR_BYTES = 512,
    parameter int                NUM_SECTORS  = 4,
    parameter logic [31:0]       SEED         = 32'h3412_0000,
    parameter int                TIMEOUT_CYC  = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    axil_pattern_if.master    m_axil
);
    localparam int N  = NUM_SECTORS * SECTOR_BYTES / 4;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    state_e            state, state_n;
    mode_e             mode_r, mode_n;
    logic [IW-1:0]     idx, idx_n;
    logic [ADDR_W-1:0] addr, addr_n, first_err_n;
    logic [31:0]       data, data_n;
    logic [15:0]       err_n;
    logic              awvalid, awvalid_n, wvalid, wvalid_n, arvalid, arvalid_n;
    logic              timeout_n, pass_n, expired, last, bad;
    axil_pattern_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_n != state),
        .expired (expired)
    );
    // sectors are contiguous, so address(i) reduces to BASE_ADDR + 4*i
    assign last            = idx == IW'(N - 1);
    assign busy            = state != IDLE && state != FINISH;
    assign done            = state == FINISH;
    assign m_axil.awaddr   = addr;
    assign m_axil.araddr   = addr;
    assign m_axil.wdata    = data;
    assign m_axil.awprot   = 3'b000;
    assign m_axil.arprot   = 3'b000;
    assign m_axil.wstrb    = 4'hF;
    assign m_axil.awvalid  = awvalid;
    assign m_axil.wvalid   = wvalid;
    assign m_axil.arvalid  = arvalid;
    assign m_axil.bready   = state == WR_RESP;
    assign m_axil.rready   = state == RD_DATA;
    // next-state, handshake and error bookkeeping
    always_comb begin
        state_n     = state;
        mode_n      = mode_r;
        idx_n       = idx;
        addr_n      = addr;
        data_n      = data;
        awvalid_n   = awvalid;
        wvalid_n    = wvalid;
        arvalid_n   = arvalid;
        err_n       = err_count;
        first_err_n = first_err_addr;
        timeout_n   = timeout;
        pass_n      = pass;
        bad         = 1'b0;
        case (state)
            IDLE: if (start) begin
                mode_n      = mode_e'(mode);
                idx_n       = '0;
                addr_n      = BASE_ADDR;
                data_n      = SEED;
                err_n       = '0;
                first_err_n = '0;
                timeout_n   = 1'b0;
                pass_n      = 1'b0;
                arvalid_n   = mode == MODE_READ;
                awvalid_n   = mode != MODE_READ;
                wvalid_n    = mode != MODE_READ;
                state_n     = mode == MODE_READ ? RD_REQ : WR_REQ;
            end
            WR_REQ: begin
                awvalid_n = awvalid && !m_axil.awready;
                wvalid_n  = wvalid && !m_axil.wready;
                state_n   = (awvalid_n || wvalid_n) ? WR_REQ : WR_RESP;
            end
            WR_RESP: if (m_axil.bvalid) begin
                bad = m_axil.bresp != OKAY;
                if (!last) begin
                    idx_n     = idx + IW'(1);
                    addr_n    = addr + ADDR_W'(4);
                    data_n    = data + 32'd1;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    state_n   = WR_REQ;
                end else if (mode_r == MODE_WR_VERIFY) begin
                    idx_n     = '0;
                    addr_n    = BASE_ADDR;
                    data_n    = SEED;
                    arvalid_n = 1'b1;
                    state_n   = RD_REQ;
                end else begin
                    state_n = FINISH;
                end
            end
            RD_REQ: begin
                arvalid_n = !m_axil.arready;
                state_n   = m_axil.arready ? RD_DATA : RD_REQ;
            end
            RD_DATA: if (m_axil.rvalid) begin
                bad       = m_axil.rresp != OKAY || m_axil.rdata != data;
                idx_n     = last ? idx : idx + IW'(1);
                addr_n    = last ? addr : addr + ADDR_W'(4);
                data_n    = last ? data : data + 32'd1;
                arvalid_n = !last;
                state_n   = last ? FINISH : RD_REQ;
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (bad) begin
            err_n       = &err_count ? err_count : err_count + 16'd1;
            first_err_n = err_count == '0 ? addr : first_err_addr;
        end
        if (busy && expired) begin
            awvalid_n = 1'b0;
            wvalid_n  = 1'b0;
            arvalid_n = 1'b0;
            timeout_n = 1'b1;
            state_n   = FINISH;
        end
        if (state_n == FINISH) pass_n = err_n == '0 && !timeout_n;
    end
    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mode_r         <= MODE_WRITE;
            idx            <= '0;
            addr           <= '0;
            data           <= '0;
            awvalid        <= 1'b0;
            wvalid         <= 1'b0;
            arvalid        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state          <= state_n;
            mode_r         <= mode_n;
            idx            <= idx_n;
            addr           <= addr_n;
            data           <= data_n;
            awvalid        <= awvalid_n;
            wvalid         <= wvalid_n;
            arvalid        <= arvalid_n;
            err_count      <= err_n;
            first_err_addr <= first_err_n;
            timeout        <= timeout_n;
            pass           <= pass_n;
        end
    end
endmodule

// File: tb/tb_axil_pattern_master.sv
// tb_axil_pattern_master: directed scenarios against a small AXI-Lite slave model
module tb_axil_pattern_master;
    localparam logic [31:0] SEED = 32'h3412_0000;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    int checks = 0, errors = 0;
    int aw_lat = 0, bad_b_idx = -1, bad_r_idx = -1, corrupt_idx = -1;
    bit aw_never = 1'b0, preload = 1'b0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, aw_wait = 0;
    logic [31:0] aw_log [64];
    logic [31:0] w_log [64];
    logic [31:0] ar_log [64];
    logic [31:0] mem [8];

    axil_pattern_if #(.ADDR_W(32)) bus ();

    axil_pattern_master #(
        .ADDR_W(32), .BASE_ADDR(32'h0), .SECTOR_BYTES(16), .NUM_SECTORS(2),
        .SEED(SEED), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_err_addr(first_err_addr), .m_axil(bus)
    );

    always #5 clk = ~clk;

    // slave model: decides on the falling edge what happens at the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; aw_wait = 0;
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
            for (int k = 0; k < 8; k++)
                mem[k] = preload ? ((SEED + 32'(k)) ^ ((k == corrupt_idx) ? 32'h1 : 32'h0)) : 32'h0;
        end else begin
            bus.bvalid = aw_cnt > b_cnt && w_cnt > b_cnt;
            bus.bresp = (b_cnt == bad_b_idx) ? 2'b10 : 2'b00;
            if (bus.bvalid && bus.bready) begin
                mem[aw_log[b_cnt % 64][4:2]] = w_log[b_cnt % 64];
                b_cnt++;
            end
            bus.rvalid = ar_cnt > r_cnt;
            bus.rdata = mem[ar_log[r_cnt % 64][4:2]];
            bus.rresp = (r_cnt == bad_r_idx) ? 2'b10 : 2'b00;
            if (bus.rvalid && bus.rready) r_cnt++;
            bus.awready = bus.awvalid && !aw_never && aw_wait >= aw_lat;
            if (bus.awready) begin
                aw_log[aw_cnt % 64] = bus.awaddr;
                aw_cnt++;
                aw_wait = 0;
            end else if (bus.awvalid) aw_wait++;
            bus.wready = bus.wvalid;
            if (bus.wready) begin
                w_log[w_cnt % 64] = bus.wdata;
                w_cnt++;
            end
            bus.arready = bus.arvalid;
            if (bus.arready) begin
                ar_log[ar_cnt % 64] = bus.araddr;
                ar_cnt++;
            end
        end
    end

    task automatic knobs(input int lat, input bit never, input int bb, input int br, input bit pre, input int cor);
        aw_lat = lat; aw_never = never; bad_b_idx = bb; bad_r_idx = br; preload = pre; corrupt_idx = cor;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] m);
        @(negedge clk);
        start = 1'b1;
        mode = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 300);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic test_reset();
        knobs(0, 0, -1, -1, 0, -1);
        do_reset();
        checks++;
        if ({busy, done, pass, timeout} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: busy/done/pass/timeout=%b required 0000", {busy, done, pass, timeout});
        end
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin
            errors++; $display("FAIL reset_bus: aw/w/ar valid b/r ready=%b required 00000",
                {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
        end
        checks++;
        if (err_count !== 16'h0 || first_err_addr !== 32'h0) begin
            errors++; $display("FAIL reset_err: err_count=%h first_err_addr=%h required 0 0", err_count, first_err_addr);
        end
        checks++;
        if (bus.awaddr !== 32'h0 || bus.wdata !== 32'h0) begin
            errors++; $display("FAIL reset_payload: addr=%h data=%h required 0 0", bus.awaddr, bus.wdata);
        end
    endtask

    task automatic test_write();
        int cyc;
        knobs(0, 0, -1, -1, 0, -1);
        do_reset();
        start_run(2'b00);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: busy=%b required 1", busy); end
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.awprot, bus.wstrb} !== {1'b1, 1'b1, 3'b000, 4'hF}) begin
            errors++; $display("FAIL write_first_beat: awvalid/wvalid/prot/strb=%b required 11_000_1111",
                {bus.awvalid, bus.wvalid, bus.awprot, bus.wstrb});
        end
        wait_done(cyc);
        checks++;
        if ({pass, busy, err_count} !== {1'b1, 1'b0, 16'h0}) begin
            errors++; $display("FAIL write_result: pass=%b busy=%b err=%0d required 1 0 0", pass, busy, err_count);
        end
        checks++;
        if (aw_cnt !== 8 || w_cnt !== 8) begin
            errors++; $display("FAIL write_beats: aw=%0d w=%0d required 8 8", aw_cnt, w_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (aw_log[k] !== 32'(k * 4) || w_log[k] !== SEED + 32'(k)) begin
                errors++; $display("FAIL write_word%0d: addr=%h data=%h required %h %h",
                    k, aw_log[k], w_log[k], 32'(k * 4), SEED + 32'(k));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || pass !== 1'b1) begin
            errors++; $display("FAIL write_after_done: done=%b pass=%b required 0 1", done, pass);
        end
    endtask

    task automatic test_verify();
        int cyc;
        knobs(0, 0, -1, -1, 0, -1);
        do_reset();
        start_run(2'b10);
        repeat (3) @(negedge clk);
        start = 1'b1;
        mode = 2'b01;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        checks++;
        if (aw_cnt !== 8 || w_cnt !== 8 || ar_cnt !== 8 || r_cnt !== 8) begin
            errors++; $display("FAIL verify_beats: aw=%0d w=%0d ar=%0d r=%0d required 8 each", aw_cnt, w_cnt, ar_cnt, r_cnt);
        end
        checks++;
        if (err_count !== 16'h0 || pass !== 1'b1) begin
            errors++; $display("FAIL verify_result: err=%0d pass=%b required 0 1", err_count, pass);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (ar_log[k] !== 32'(k * 4)) begin
                errors++; $display("FAIL verify_araddr%0d: got %h required %h", k, ar_log[k], 32'(k * 4));
            end
        end
    endtask

    task automatic test_read_corrupt();
        int cyc;
        knobs(0, 0, -1, 5, 1, 5);
        do_reset();
        start_run(2'b01);
        wait_done(cyc);
        checks++;
        if (err_count !== 16'd1 || first_err_addr !== 32'h14 || pass !== 1'b0) begin
            errors++; $display("FAIL corrupt_result: err=%0d first=%h pass=%b required 1 14 0", err_count, first_err_addr, pass);
        end
        checks++;
        if (aw_cnt !== 0 || r_cnt !== 8) begin
            errors++; $display("FAIL corrupt_beats: aw=%0d r=%0d required 0 8", aw_cnt, r_cnt);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        knobs(3, 0, 2, -1, 0, -1);
        do_reset();
        start_run(2'b00);
        wait_done(cyc);
        checks++;
        if (aw_cnt !== 8 || w_cnt !== 8 || b_cnt !== 8) begin
            errors++; $display("FAIL bp_beats: aw=%0d w=%0d b=%0d required 8 8 8", aw_cnt, w_cnt, b_cnt);
        end
        checks++;
        if (err_count !== 16'd1 || first_err_addr !== 32'h8 || pass !== 1'b0) begin
            errors++; $display("FAIL bp_result: err=%0d first=%h pass=%b required 1 8 0", err_count, first_err_addr, pass);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (aw_log[k] !== 32'(k * 4) || w_log[k] !== SEED + 32'(k)) begin
                errors++; $display("FAIL bp_word%0d: addr=%h data=%h required %h %h",
                    k, aw_log[k], w_log[k], 32'(k * 4), SEED + 32'(k));
            end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        knobs(0, 1, -1, -1, 0, -1);
        do_reset();
        start_run(2'b00);
        wait_done(cyc);
        checks++;
        if (cyc !== 17) begin errors++; $display("FAIL timeout_latency: done after %0d cycles required 17", cyc); end
        checks++;
        if (timeout !== 1'b1 || pass !== 1'b0) begin
            errors++; $display("FAIL timeout_flags: timeout=%b pass=%b required 1 0", timeout, pass);
        end
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid} !== 3'b0) begin
            errors++; $display("FAIL timeout_valids: %b required 000", {bus.awvalid, bus.wvalid, bus.arvalid});
        end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL timeout_hold: timeout=%b done=%b required 1 0", timeout, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int seen = 0;
        knobs(0, 0, -1, -1, 1, 0);
        do_reset();
        start_run(2'b01);
        for (int n = 0; n < 100 && seen < 2; n++) begin
            @(negedge clk);
            if (bus.rready) seen++;
        end
        checks++;
        if (seen !== 2 || err_count !== 16'd1) begin
            errors++; $display("FAIL midrst_pre: rd_data visits=%0d err=%0d required 2 1", seen, err_count);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, pass, timeout, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 9'b0) begin
            errors++; $display("FAIL midrst_flags: %b required 000000000",
                {busy, done, pass, timeout, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
        end
        checks++;
        if (err_count !== 16'h0 || first_err_addr !== 32'h0 || bus.araddr !== 32'h0) begin
            errors++; $display("FAIL midrst_regs: err=%0d first=%h addr=%h required 0 0 0", err_count, first_err_addr, bus.araddr);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: done=%b required 0", done); end
        start_run(2'b00);
        checks++;
        if (bus.awvalid !== 1'b1 || bus.awaddr !== 32'h0 || bus.wdata !== SEED) begin
            errors++; $display("FAIL midrst_restart: awvalid=%b addr=%h data=%h required 1 0 %h",
                bus.awvalid, bus.awaddr, bus.wdata, SEED);
        end
        wait_done(cyc);
        checks++;
        if (aw_cnt !== 8 || w_log[7] !== SEED + 32'd7 || pass !== 1'b1) begin
            errors++; $display("FAIL midrst_run: aw=%0d last_data=%h pass=%b required 8 %h 1",
                aw_cnt, w_log[7], pass, SEED + 32'd7);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_verify();
        test_read_corrupt();
        test_backpressure();
        test_timeout();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axil_pattern_master.md
AXIL_PATTERN_MASTER -- requirements
Module: axil_pattern_master

Interface
REQ-001 Parameter ADDR_W, 32, AXI-Lite address width.
REQ-002 Parameter BASE_ADDR, 0, byte address of first word written/read.
REQ-003 Parameter SECTOR_BYTES, 512, bytes per sector; power of two, multiple of 4.
REQ-004 Parameter NUM_SECTORS, 4, sectors covered per run (>=1).
REQ-005 Parameter SEED, 32'h3412_0000, pattern base value.
REQ-006 Parameter TIMEOUT_CYC, 1_000_000, max cycles waiting on any single handshake.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 start  in  1  one-cycle run request; sampled only in IDLE.
REQ-010 mode  in  2  00 write, 01 read-verify, 10 write-then-verify, 11 reserved (treated as 00); latched with start.
REQ-011 busy  out  1  high from cycle after accepted start until done pulse.
REQ-012 done  out  1  one-cycle pulse at end of run.
REQ-013 pass  out  1  valid after done: err_count==0 and no timeout; held until next start.
REQ-014 timeout  out  1  run aborted on handshake timeout; held until next start.
REQ-015 err_count  out  16  saturating count of bad responses plus data mismatches.
REQ-016 first_err_addr  out  ADDR_W  address of first error of run; 0 if none.
REQ-017 m_axil_aw{addr,prot,valid}/awready, w{data,strb,valid}/wready, b{resp,valid}/bready, ar{addr,prot,valid}/arready, r{data,resp,valid}/rready  AXI-Lite master, 32-bit data; prot fixed 000, wstrb fixed 1111.

Function
REQ-018 WPS = SECTOR_BYTES/4; total words N = NUM_SECTORS*WPS; word index i runs 0..N-1 exactly, no extra word.
REQ-019 Address(i) = BASE_ADDR + sector*SECTOR_BYTES + word*4, ADDR_W-bit modulo; pattern(i) = SEED + i, 32-bit modulo.
REQ-020 States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, FINISH.
REQ-021 IDLE: start -> clear err_count/first_err_addr/timeout/pass, i=0; mode 00/10/11 -> WR_REQ, 01 -> RD_REQ.
REQ-022 WR_REQ: awvalid and wvalid asserted together with addr/data of i; each deasserted independently on its ready handshake; payload stable while valid; once both accepted (incl. same cycle) -> WR_RESP.
REQ-023 WR_RESP: bready=1; on bvalid, bresp!=00 counts error; if i==N-1: mode 10 -> RD_REQ with i=0, else FINISH; otherwise i+1 -> WR_REQ.
REQ-024 RD_REQ: arvalid with address(i) until arready -> RD_DATA.
REQ-025 RD_DATA: rready=1; on rvalid, rresp!=00 or rdata!=pattern(i) counts one error (not two); i==N-1 -> FINISH else i+1 -> RD_REQ.
REQ-026 First error of run captures address(i) into first_err_addr; later errors do not update it.
REQ-027 err_count saturates at 16'hFFFF.
REQ-028 Timeout counter cleared on every state entry; reaching TIMEOUT_CYC in WR_REQ/WR_RESP/RD_REQ/RD_DATA drops all valids, sets timeout -> FINISH.
REQ-029 FINISH: done=1 for one cycle, pass computed, -> IDLE; busy low from the done cycle.
REQ-030 start while not in IDLE is ignored; bready/rready low outside WR_RESP/RD_DATA.

Reset
REQ-031 rst sets state IDLE, all valids/readies 0, addr/data 0, busy/done/pass/timeout 0, err_count 0, first_err_addr 0, i 0.
REQ-032 rst mid-transaction abandons it immediately; no done pulse is produced.

Structure
REQ-033 Package axil_pattern_pkg holds state enum, mode enum, and AXI resp constant OKAY=2'b00.
REQ-034 One sub-module axil_pattern_timeout (counter, clear, expired flag) is natural; rest is flat.

Verification
REQ-035 NUM_SECTORS=2, SECTOR_BYTES=16, mode 00, zero-wait slave -> 8 writes, addr 0x00..0x1C, data 0x34120000..0x34120007, done, pass=1.
REQ-036 Same, mode 10, slave memory model -> 8 writes then 8 reads, err_count=0, pass=1.
REQ-037 Mode 01 on memory with word 5 corrupted -> err_count=1, first_err_addr=0x14, pass=0.
REQ-038 Slave asserts wready 3 cycles before awready, bresp=10 on word 2 -> no duplicate beats, err_count=1, first_err_addr=0x08.
REQ-039 TIMEOUT_CYC=16, slave never asserts awready -> timeout=1 and done 17 cycles after awvalid rises, pass=0.
REQ-040 rst asserted during RD_DATA, then start mode 00 -> all outputs at reset values, new run starts at i=0.
